// File: rtl/dbg_bridge_pkg.sv
// Shared opcodes and state types for the UART debug bridge.
// Imported by the bridge top and its byte receiver.
package dbg_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    P_CMD,
    P_ADDR,
    P_DATA,
    P_BUS,
    P_RESP
  } parse_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchroniser, start-bit validation,
// mid-bit sampling, byte strobe and framing-error strobe.
module uart_byte_rx
  import dbg_bridge_pkg::*;
#(
  parameter int CLK_DIV = 867
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam logic [15:0] DIV  = 16'(CLK_DIV);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);

  rx_state_e   st;
  rx_state_e   st_nxt;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  sh;
  logic        tick;

  assign tick      = (cnt == 16'd0);
  assign byte_data = sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= R_IDLE;
    else        st <= st_nxt;
  end

  // A bad stop bit leaves the line low; wait for it
  // to go high so the break is not taken as a start.
  always_comb begin
    st_nxt = st;
    unique case (st)
      R_IDLE:  if (!rx_s) st_nxt = R_START;
      R_START: if (tick) st_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bit_idx == 3'd7) st_nxt = R_STOP;
      R_STOP:  if (tick) st_nxt = rx_s ? R_IDLE : R_WAIT;
      R_WAIT:  if (rx_s) st_nxt = R_IDLE;
      default: st_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      sh         <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (st == R_IDLE || st == R_WAIT) cnt <= HALF;
      else if (tick)                    cnt <= DIV;
      else                              cnt <= cnt - 16'd1;
      if (st == R_DATA && tick) begin
        sh      <= {rx_s, sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (st == R_STOP && tick) begin
        byte_valid <= rx_s;
        frame_err  <= !rx_s;
      end
    end
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: parses W/R command frames from a host
// and runs them as transactions on the valid/ready bus.
module uart_dbg_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int CLK_DIV     = 867,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        err
);

  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC - 1);
  localparam logic [15:0] DIV = 16'(CLK_DIV);

  parse_state_e state;
  parse_state_e state_nxt;

  logic          rx_valid;
  logic          rx_ferr;
  logic [7:0]    rx_data;
  logic          is_cmd;
  logic          in_field;
  logic [1:0]    idx;
  logic [GW-1:0] gap;
  logic          err_nxt;
  logic          bad_op;
  logic          bus_go;
  logic          rsp_go;

  logic [9:0]  tx_sh;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [23:0] tx_buf;
  logic [1:0]  tx_left;
  logic        tx_active;
  logic        tx_tick;
  logic        tx_done;
  logic        tx_load;
  logic [7:0]  tx_byte;

  uart_byte_rx #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  assign is_cmd   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign in_field = (state == P_ADDR) || (state == P_DATA);
  assign busy     = (state != P_CMD);
  assign uart_tx  = tx_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= P_CMD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    bad_op    = 1'b0;
    bus_go    = 1'b0;
    rsp_go    = 1'b0;
    unique case (state)
      P_CMD: begin
        unique case (1'b1)
          rx_ferr:              err_nxt = 1'b1;
          rx_valid && is_cmd:   state_nxt = P_ADDR;
          rx_valid && !is_cmd: begin
            bad_op  = 1'b1;
            err_nxt = 1'b1;
          end
          default: ;
        endcase
      end
      P_ADDR, P_DATA: begin
        if (rx_ferr) begin
          state_nxt = P_CMD;
          err_nxt   = 1'b1;
        end else if (rx_valid) begin
          if (idx == 2'd3) begin
            if (state == P_ADDR && bus_we) begin
              state_nxt = P_DATA;
            end else begin
              state_nxt = P_BUS;
              bus_go    = 1'b1;
            end
          end
        end else if (gap == GAP_MAX) begin
          state_nxt = P_CMD;
          err_nxt   = 1'b1;
        end
      end
      P_BUS: begin
        err_nxt = rx_valid | rx_ferr;
        if (bus_ready) begin
          state_nxt = P_RESP;
          rsp_go    = 1'b1;
        end
      end
      P_RESP: begin
        err_nxt = rx_valid | rx_ferr;
        if (tx_done) state_nxt = P_CMD;
      end
      default: state_nxt = P_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      idx       <= 2'd0;
      gap       <= '0;
    end else begin
      err       <= err_nxt;
      bus_valid <= bus_go | (bus_valid & ~bus_ready);
      if (state == P_CMD && state_nxt == P_ADDR)
        bus_we <= (rx_data == CMD_WR);
      if (state_nxt == P_CMD)      idx <= 2'd0;
      else if (in_field && rx_valid) idx <= idx + 2'd1;
      if (state == P_ADDR && rx_valid)
        bus_addr <= {rx_data, bus_addr[31:8]};
      if (state == P_DATA && rx_valid)
        bus_wdata <= {rx_data, bus_wdata[31:8]};
      if (rx_valid || !in_field) gap <= '0;
      else                       gap <= gap + 1'b1;
    end
  end

  // Reply shifter; read data goes out LSB byte first
  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_done = tx_active && tx_tick &&
                   (tx_bit == 4'd9) && (tx_left == 2'd0);
  assign tx_load = rsp_go || (bad_op && !tx_active);

  always_comb begin
    tx_byte = RSP_ERR;
    if (rsp_go) tx_byte = bus_we ? RSP_OK : bus_rdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh     <= 10'h3FF;
      tx_cnt    <= 16'd0;
      tx_bit    <= 4'd0;
      tx_buf    <= 24'd0;
      tx_left   <= 2'd0;
      tx_active <= 1'b0;
    end else if (tx_load) begin
      tx_sh     <= {1'b1, tx_byte, 1'b0};
      tx_cnt    <= DIV;
      tx_bit    <= 4'd0;
      tx_buf    <= bus_rdata[31:8];
      tx_left   <= (rsp_go && !bus_we) ? 2'd3 : 2'd0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (!tx_tick) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= DIV;
        if (tx_bit != 4'd9) begin
          tx_sh  <= {1'b1, tx_sh[9:1]};
          tx_bit <= tx_bit + 4'd1;
        end else if (tx_left != 2'd0) begin
          tx_sh   <= {1'b1, tx_buf[7:0], 1'b0};
          tx_buf  <= {8'd0, tx_buf[23:8]};
          tx_left <= tx_left - 2'd1;
          tx_bit  <= 4'd0;
        end else begin
          tx_active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Randomised bench for uart_dbg_bridge against a frame-level
// model: host UART driver, bus responder, reply decoder.
module tb_uart_dbg_bridge;

  localparam int DIV = 15;
  localparam int TMO = 2000;
  localparam int BIT = DIV + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic        uart_tx;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  frm[$];
  logic [7:0]  tx_q[$];
  int          tx_t[$];
  int          bad_stop = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;
  int          nvalid = 0;
  int          rdy_cyc = 0;
  int          last_end = 0;
  int          gap_max = 0;
  logic        log_we;
  logic [31:0] log_addr;
  logic [31:0] log_wdata;
  int          lat = 0;
  logic [31:0] rd_val = 32'd0;
  logic        hold_bus = 1'b0;
  logic        go = 1'b0;
  logic        prev_v;
  int          wcnt;
  logic [7:0]  mon_b;
  int          mon_t0;

  uart_dbg_bridge #(
    .CLK_DIV    (DIV),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .bus_valid(bus_valid),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ready(bus_ready),
    .bus_rdata(bus_rdata),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (rst_n && bus_valid && !prev_v) nvalid++;
      prev_v = bus_valid;
    end
  end

  initial begin
    bus_ready = 1'b0;
    bus_rdata = 32'd0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (bus_ready || !bus_valid || hold_bus) begin
        bus_ready = 1'b0;
        wcnt = 0;
      end else if (wcnt < lat) begin
        wcnt++;
      end else begin
        bus_ready = 1'b1;
        bus_rdata = rd_val;
        log_we    = bus_we;
        log_addr  = bus_addr;
        log_wdata = bus_wdata;
        rdy_cyc   = cyc;
      end
    end
  end

  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        mon_t0 = cyc;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (BIT) @(negedge clk);
        if (uart_tx !== 1'b1) bad_stop++;
        tx_q.push_back(mon_b);
        tx_t.push_back(mon_t0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    last_end = cyc;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    tx_t.delete();
    err_cnt = 0;
    nvalid = 0;
    bad_stop = 0;
  endtask

  task automatic run_frame();
    logic [7:0]  exp[$];
    int          exp_bus;
    int          exp_err;
    logic        exp_we;
    logic [31:0] a;
    logic [31:0] d;
    exp_bus = 0;
    exp_err = 0;
    exp_we  = 1'b0;
    a = 32'd0;
    d = 32'd0;
    if (frm[0] == 8'h57 || frm[0] == 8'h52) begin
      exp_bus = 1;
      exp_we  = (frm[0] == 8'h57);
      for (int i = 0; i < 4; i++) a[8*i +: 8] = frm[1+i];
      if (exp_we) begin
        for (int i = 0; i < 4; i++) d[8*i +: 8] = frm[5+i];
        exp.push_back(8'h4B);
      end else begin
        for (int i = 0; i < 4; i++) exp.push_back(rd_val[8*i +: 8]);
      end
    end else begin
      exp.push_back(8'h3F);
      exp_err = 1;
    end
    clear_mon();
    foreach (frm[i]) begin
      send_byte(frm[i], 1'b1);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    for (int k = 0; k < 8000 && tx_q.size() < exp.size(); k++)
      @(negedge clk);
    repeat (20) @(negedge clk);
    chk("bus_cnt", nvalid, exp_bus);
    if (exp_bus != 0) begin
      chk("bus_we", log_we, exp_we);
      chk("bus_addr", log_addr, a);
      if (exp_we) chk("bus_wdata", log_wdata, d);
    end
    chk("rsp_len", tx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++) begin
      chk("rsp_byte", tx_q[i], exp[i]);
      if (i > 0) chk("rsp_gap", tx_t[i] - tx_t[i-1], 10 * BIT);
    end
    if (exp_bus != 0 && tx_t.size() > 0)
      chk("rsp_lat", tx_t[0] - rdy_cyc, 1);
    chk("err_cnt", err_cnt, exp_err);
    chk("stop_bits", bad_stop, 0);
    chk("busy_end", busy, 1'b0);
  endtask

  task automatic rand_frame();
    int          sel;
    logic [7:0]  op;
    sel = $urandom_range(0, 4);
    lat = $urandom_range(0, 6);
    rd_val = $urandom;
    gap_max = 40;
    frm.delete();
    if (sel < 2) op = 8'h57;
    else if (sel < 4) op = 8'h52;
    else begin
      op = 8'($urandom_range(0, 255));
      if (op == 8'h57 || op == 8'h52) op = 8'h00;
    end
    frm.push_back(op);
    if (op == 8'h57 || op == 8'h52)
      for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
    if (op == 8'h57)
      for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
    run_frame();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    uart_rx = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    go = 1'b1;
    repeat (50) @(negedge clk);

    frm = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h40,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    lat = 2;
    run_frame();

    frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h40};
    lat = 3;
    rd_val = 32'h0000_0367;
    run_frame();

    frm = '{8'h41};
    run_frame();
    frm = '{8'h57, 8'h04, 8'h00, 8'h00, 8'h20,
            8'h11, 8'h22, 8'h33, 8'h44};
    lat = 0;
    run_frame();

    clear_mon();
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    chk("to_busy", busy, 1'b1);
    mon_t0 = last_end;
    repeat (2500) @(negedge clk);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_err_win", (err_cyc - mon_t0 >= 1991) &&
                      (err_cyc - mon_t0 <= 1999), 1'b1);
    chk("to_busy_end", busy, 1'b0);
    chk("to_bus", nvalid, 0);
    chk("to_rsp", tx_q.size(), 0);
    frm = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h40};
    rd_val = 32'hCAFE_F00D;
    lat = 1;
    run_frame();

    clear_mon();
    send_byte(8'h57, 1'b1);
    send_byte(8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    chk("fe_err", err_cnt, 1);
    chk("fe_busy", busy, 1'b0);
    chk("fe_rsp", tx_q.size(), 0);

    clear_mon();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("gl_err", err_cnt, 0);
    chk("gl_busy", busy, 1'b0);
    chk("gl_rsp", tx_q.size(), 0);

    for (int r = 0; r < 6; r++) rand_frame();
    gap_max = 0;

    clear_mon();
    hold_bus = 1'b1;
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    for (int k = 0; k < 400 && !bus_valid; k++) @(negedge clk);
    chk("ra_valid", bus_valid, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_rst_valid", bus_valid, 1'b0);
    chk("ra_rst_tx", uart_tx, 1'b1);
    chk("ra_rst_busy", busy, 1'b0);
    chk("ra_rst_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_bus = 1'b0;
    clear_mon();
    repeat (1000) @(negedge clk);
    chk("ra_no_rsp", tx_q.size(), 0);
    chk("ra_no_bus", nvalid, 0);
    chk("ra_no_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
